// File: rtl/fuzzy_pkg.sv
// Shared constants and state encoding for the fuzzy controller back end.
// Q1.15 limits, percent full scale, defuzzifier FSM states.
package fuzzy_pkg;

  localparam logic [15:0] Q15_MAX  = 16'd32767;
  localparam logic [15:0] Q15_HALF = 16'd16384;
  localparam int          PCT_MAX  = 100;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } defuzz_state_t;

  // Q1.15 to rounded percent, clamped at full scale
  function automatic logic [7:0] q15_to_pct(input logic [15:0] y);
    logic [22:0] p;
    p = 23'(y) * 23'd100 + 23'(Q15_HALF);
    if (p[22:15] > 8'(PCT_MAX))
      return 8'(PCT_MAX);
    return p[22:15];
  endfunction

endpackage

// File: rtl/seq_div_q15.sv
// Restoring divider: one quotient bit per cycle, MSB first.
// Loads on start, pulses done one cycle after the last bit.
module seq_div_q15
  import fuzzy_pkg::*;
#(
  parameter int W  = 16,
  parameter int QF = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*W-2:0]  numerator,
  input  logic [W-1:0]    divisor,
  output logic [W-1:0]    quotient,
  output logic            done
);

  localparam int CW = $clog2(QF);

  logic [W-1:0]  r_rem;
  logic [QF-1:0] r_low;
  logic [QF-1:0] r_q;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic [W:0]    w_t;
  logic          w_ge;
  logic [W-1:0]  w_sub;

  // 17-bit partial remainder: previous remainder plus next numerator bit
  assign w_t   = {r_rem, r_low[QF-1]};
  assign w_ge  = (w_t >= {1'b0, r_div});
  assign w_sub = W'(w_t - {1'b0, r_div});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_low  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (start) begin
      r_rem  <= numerator[2*W-2:QF];
      r_low  <= numerator[QF-1:0];
      r_q    <= '0;
      r_div  <= divisor;
      r_cnt  <= CW'(QF - 1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_sub : w_t[W-1:0];
      r_low <= r_low << 1;
      r_q   <= {r_q[QF-2:0], w_ge};
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign quotient = {{(W-QF){1'b0}}, r_q};
  assign done     = r_done;

endmodule

// File: rtl/defuzz_divider.sv
// Centre-of-gravity defuzzifier: y = S_wg / S_w, rounded, Q1.15 and percent.
// Fixed 17-cycle latency from acceptance to out_valid.
module defuzz_divider
  import fuzzy_pkg::*;
#(
  parameter int W  = 16,
  parameter int QF = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] S_w,
  input  logic [W-1:0] S_wg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y_q15,
  output logic [7:0]   y_pct,
  output logic         div0,
  output logic         sat
);

  defuzz_state_t r_state;
  defuzz_state_t w_next;

  logic [W-1:0]   r_sw;
  logic [W-1:0]   r_swg;
  logic [W-1:0]   r_y;
  logic [7:0]     r_pct;
  logic           r_div0;
  logic           r_sat;

  logic           w_accept;
  logic [2*W-2:0] w_num;
  logic [W-1:0]   w_quot;
  logic           w_done;
  logic [W-1:0]   w_y;
  logic           w_div0;
  logic           w_sat;

  assign w_accept = in_valid && (r_state == IDLE);

  // Adding S_w/2 makes the floor division round half up
  assign w_num = ((2*W-1)'(S_wg) << QF) + (2*W-1)'(S_w >> 1);

  seq_div_q15 #(
    .W  (W),
    .QF (QF)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_accept),
    .numerator (w_num),
    .divisor   (S_w),
    .quotient  (w_quot),
    .done      (w_done)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid)  w_next = DIV;
      DIV:  if (w_done)    w_next = NORM;
      NORM:                w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
    endcase
  end

  always_comb begin
    w_y    = w_quot;
    w_div0 = 1'b0;
    w_sat  = 1'b0;
    if (r_sw == '0) begin
      w_y    = '0;
      w_div0 = 1'b1;
    end else if (r_swg >= r_sw) begin
      w_y   = W'(Q15_MAX);
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sw    <= '0;
      r_swg   <= '0;
      r_y     <= '0;
      r_pct   <= '0;
      r_div0  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sw  <= S_w;
        r_swg <= S_wg;
      end
      if (r_state == NORM) begin
        r_y    <= w_y;
        r_pct  <= q15_to_pct(16'(w_y));
        r_div0 <= w_div0;
        r_sat  <= w_sat;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign y_q15     = r_y;
  assign y_pct     = r_pct;
  assign div0      = r_div0;
  assign sat       = r_sat;

endmodule
